// File: rtl/frame_capture_sink.sv
// Avalon-ST RGB101010 sink. Each beat is reduced to RGB444 and one WIDTH x HEIGHT
// frame is written into a BRAM buffer, which downstream readers access through a synchronous read port.
//
// state    | meaning
// IDLE     | beats discarded, waiting for arm or continuous
// WAIT_SOP | armed, beats discarded until a start-of-packet beat arrives
// CAPTURE  | writing pixels row-major into the frame buffer
module frame_capture_sink #(
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 240,
   parameter int ADDR_W = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [29:0]       data_i,
   input  logic              startofpacket_i,
   input  logic              endofpacket_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              arm_i,
   input  logic              continuous_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [11:0]       rd_data_o,
   output logic              busy_o,
   output logic              frame_done_o,
   output logic              frame_error_o,
   output logic [7:0]        frame_count_o
);

   localparam int DEPTH = WIDTH * HEIGHT;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
   localparam bit LAST_IS_ZERO = (DEPTH == 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOP = 2'd1,
      CAPTURE  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        frame_count_q, frame_count_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
   logic              ready_q;
   logic [11:0]       rd_data_q;

   logic              beat;
   logic              wr_en;
   logic              mem_we;
   logic [ADDR_W-1:0] wr_ptr;
   logic [11:0]       pixel;
   logic              unused_pad_bits;

   logic [11:0] mem [0:DEPTH-1];

   assign beat  = valid_i && ready_q;
   assign pixel = {data_i[29:26], data_i[19:16], data_i[9:6]};
   assign unused_pad_bits = ^{data_i[25:20], data_i[15:10], data_i[5:0]};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         wr_addr_q     <= '0;
         frame_count_q <= 8'd0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         busy_q        <= 1'b0;
         ready_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         frame_count_q <= frame_count_d;
         done_q        <= done_d;
         err_q         <= err_d;
         busy_q        <= busy_d;
         ready_q       <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      wr_en     = 1'b0;
      wr_ptr    = wr_addr_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (arm_i || continuous_i) state_d = WAIT_SOP;
         end
         WAIT_SOP, CAPTURE: begin
            if (beat && startofpacket_i) begin
               wr_en  = 1'b1;
               wr_ptr = '0;
               if (endofpacket_i) begin
                  // a one-beat frame is only legal when the buffer holds one pixel
                  wr_addr_d = '0;
                  if (LAST_IS_ZERO) begin
                     done_d  = 1'b1;
                     state_d = continuous_i ? WAIT_SOP : IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = WAIT_SOP;
                  end
               end else begin
                  err_d     = (state_q == CAPTURE);
                  wr_addr_d = ADDR_W'(1);
                  state_d   = CAPTURE;
               end
            end else if (beat && state_q == CAPTURE) begin
               wr_en = 1'b1;
               if (endofpacket_i || wr_addr_q == LAST) begin
                  wr_addr_d = '0;
                  if (endofpacket_i && wr_addr_q == LAST) begin
                     done_d  = 1'b1;
                     state_d = continuous_i ? WAIT_SOP : IDLE;
                  end else begin
                     err_d   = 1'b1;
                     state_d = WAIT_SOP;
                  end
               end else begin
                  wr_addr_d = wr_addr_q + ADDR_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_d        = (state_d != IDLE);
      frame_count_d = frame_count_q + {7'd0, done_d};
      mem_we        = wr_en && !rst_i;
   end

   // Frame buffer: no reset, read-before-write on a same-address collision.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[wr_ptr] <= pixel;
      rd_data_q <= mem[rd_addr_i];
   end

   assign ready_o       = ready_q;
   assign rd_data_o     = rd_data_q;
   assign busy_o        = busy_q;
   assign frame_done_o  = done_q;
   assign frame_error_o = err_q;
   assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_frame_capture_sink.sv
// Bench for frame_capture_sink on a small 8x4 buffer plus a 1x1 instance.
// A table of frame scenarios is driven first, then the multi-cycle corner sequences.
module tb_frame_capture_sink;

   localparam int W  = 8;
   localparam int H  = 4;
   localparam int N  = W * H;
   localparam int AW = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic [29:0]   data = '0;
   logic          sop = 1'b0, eop = 1'b0, valid = 1'b0;
   logic          ready;
   logic          arm = 1'b0, cont = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [11:0]   rd_data;
   logic          busy, frame_done, frame_error;
   logic [7:0]    frame_count;

   logic [29:0]   data1 = '0;
   logic          sop1 = 1'b0, eop1 = 1'b0, valid1 = 1'b0;
   logic          ready1;
   logic          arm1 = 1'b0, cont1 = 1'b0;
   logic [0:0]    rd_addr1 = '0;
   logic [11:0]   rd_data1;
   logic          busy1, done1, err1;
   logic [7:0]    count1;

   frame_capture_sink #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk_i(clk), .rst_i(rst), .data_i(data), .startofpacket_i(sop),
      .endofpacket_i(eop), .valid_i(valid), .ready_o(ready), .arm_i(arm),
      .continuous_i(cont), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
      .busy_o(busy), .frame_done_o(frame_done), .frame_error_o(frame_error),
      .frame_count_o(frame_count)
   );

   frame_capture_sink #(.WIDTH(1), .HEIGHT(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .data_i(data1), .startofpacket_i(sop1),
      .endofpacket_i(eop1), .valid_i(valid1), .ready_o(ready1), .arm_i(arm1),
      .continuous_i(cont1), .rd_addr_i(rd_addr1), .rd_data_o(rd_data1),
      .busy_o(busy1), .frame_done_o(done1), .frame_error_o(err1),
      .frame_count_o(count1)
   );

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   bit done_at_eop;
   logic [11:0] exp_mem [N];

   always @(negedge clk) begin
      if (frame_done === 1'b1) done_cnt++;
      if (frame_error === 1'b1) err_cnt++;
   end

   typedef struct {
      bit do_arm;
      bit cont;
      int n;
      int restart;
      bit gaps;
      bit cap;
      bit chk_mem;
      int exp_done;
      int exp_err;
      int exp_count;
      bit exp_busy;
   } vec_t;

   vec_t vecs[12];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   function automatic logic [29:0] mk(input int seed, input int i);
      logic [9:0] v;
      v = 10'(seed * 131 + i * 71);
      return {v, v ^ 10'h155, v + 10'h2A3};
   endfunction

   function automatic logic [11:0] xp(input logic [29:0] d);
      return {d[29:26], d[19:16], d[9:6]};
   endfunction

   // One frame of n beats, SOP on beat 0 (and on beat 'restart' if >0), EOP on the last beat.
   task automatic stream(input int seed, input int n, input int restart, input bit gaps, input bit cap);
      int a;
      int g;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               valid = 1'b0; sop = 1'b1; eop = 1'b1; data = '1;
               step();
            end
         end
         data  = mk(seed, i);
         valid = 1'b1;
         sop   = (i == 0) || (restart > 0 && i == restart);
         eop   = (i == n - 1);
         step();
         a = (restart > 0 && i >= restart) ? i - restart : i;
         if (cap && a < N) exp_mem[a] = xp(mk(seed, i));
         done_at_eop = (frame_done === 1'b1);
      end
      valid = 1'b0; sop = 1'b0; eop = 1'b0;
   endtask

   task automatic memcheck(input string nm);
      for (int a = 0; a < N; a++) begin
         rd_addr = AW'(a);
         step();
         chk($sformatf("%s mem[%0d]", nm, a), rd_data, exp_mem[a]);
      end
   endtask

   initial begin
      int d0, e0;
      logic [11:0] old_px, new_px;

      vecs[0]  = '{1, 0, 32, 0, 0, 1, 1, 1, 0, 1, 0};
      vecs[1]  = '{0, 0, 32, 0, 0, 0, 1, 0, 0, 1, 0};
      vecs[2]  = '{1, 0, 10, 0, 0, 1, 1, 0, 1, 1, 1};
      vecs[3]  = '{0, 0,  1, 0, 0, 0, 0, 0, 1, 1, 1};
      vecs[4]  = '{0, 0, 32, 0, 0, 1, 1, 1, 0, 2, 0};
      vecs[5]  = '{1, 0, 37, 5, 0, 1, 1, 1, 1, 3, 0};
      vecs[6]  = '{1, 0, 34, 0, 0, 1, 1, 0, 1, 3, 1};
      vecs[7]  = '{0, 1, 32, 0, 0, 1, 0, 1, 0, 4, 1};
      vecs[8]  = '{0, 1, 32, 0, 1, 1, 0, 1, 0, 5, 1};
      vecs[9]  = '{0, 1, 32, 0, 1, 1, 1, 1, 0, 6, 1};
      vecs[10] = '{0, 0, 32, 0, 0, 1, 1, 1, 0, 7, 0};
      vecs[11] = '{0, 0, 32, 0, 0, 0, 1, 0, 0, 7, 0};

      repeat (3) step();
      chk("rst ready", ready, 1'b0);
      chk("rst busy", busy, 1'b0);
      chk("rst done", frame_done, 1'b0);
      chk("rst err", frame_error, 1'b0);
      chk("rst count", frame_count, 8'd0);
      rst = 1'b0;
      step();
      chk("post-rst ready", ready, 1'b1);

      for (int t = 0; t < 12; t++) begin
         cont = vecs[t].cont;
         if (vecs[t].do_arm) begin
            arm = 1'b1; step(); arm = 1'b0;
         end
         d0 = done_cnt; e0 = err_cnt;
         stream(t + 1, vecs[t].n, vecs[t].restart, vecs[t].gaps, vecs[t].cap);
         step();
         chk($sformatf("v%0d done pulses", t), done_cnt - d0, vecs[t].exp_done);
         chk($sformatf("v%0d err pulses", t), err_cnt - e0, vecs[t].exp_err);
         chk($sformatf("v%0d done after eop", t), done_at_eop, vecs[t].exp_done);
         chk($sformatf("v%0d done width", t), frame_done, 1'b0);
         chk($sformatf("v%0d count", t), frame_count, vecs[t].exp_count);
         chk($sformatf("v%0d busy", t), busy, vecs[t].exp_busy);
         chk($sformatf("v%0d ready", t), ready, 1'b1);
         if (vecs[t].chk_mem) memcheck($sformatf("v%0d", t));
      end

      // single-pixel buffer: SOP+EOP in one beat is a complete frame
      arm1 = 1'b1; step(); arm1 = 1'b0;
      data1 = mk(70, 0); sop1 = 1'b1; eop1 = 1'b1; valid1 = 1'b1;
      step();
      valid1 = 1'b0;
      chk("1x1 done", done1, 1'b1);
      chk("1x1 err", err1, 1'b0);
      chk("1x1 count", count1, 8'd1);
      chk("1x1 busy", busy1, 1'b0);
      rd_addr1 = 1'b0;
      step();
      chk("1x1 done width", done1, 1'b0);
      chk("1x1 rd", rd_data1, xp(mk(70, 0)));
      cont1 = 1'b1;
      step();
      valid1 = 1'b1; data1 = mk(71, 0);
      step();
      data1 = mk(72, 0);
      step();
      valid1 = 1'b0;
      step();
      chk("1x1 cont count", count1, 8'd3);
      chk("1x1 cont busy", busy1, 1'b1);
      chk("1x1 cont rd", rd_data1, xp(mk(72, 0)));

      // read latency: rd_data follows rd_addr one edge later
      rd_addr = AW'(3);
      step();
      chk("lat addr3", rd_data, exp_mem[3]);
      rd_addr = AW'(4);
      #1;
      chk("lat hold", rd_data, exp_mem[3]);
      step();
      chk("lat addr4", rd_data, exp_mem[4]);

      // read-during-write at address 0 returns the old pixel
      arm = 1'b1; step(); arm = 1'b0;
      rd_addr = '0;
      step();
      old_px = exp_mem[0];
      new_px = xp(mk(55, 0));
      data = mk(55, 0); sop = 1'b1; valid = 1'b1;
      step();
      chk("rdw old", rd_data, old_px);
      exp_mem[0] = new_px;
      valid = 1'b0; sop = 1'b0;
      step();
      chk("rdw new", rd_data, new_px);
      for (int i = 1; i < 20; i++) begin
         data = mk(55, i); valid = 1'b1;
         step();
         exp_mem[i] = xp(mk(55, i));
      end

      // reset mid-capture: beats during reset are not written, no pulses
      d0 = done_cnt; e0 = err_cnt;
      data = mk(56, 20); rst = 1'b1;
      step();
      chk("midrst ready", ready, 1'b0);
      data = mk(56, 21);
      step();
      step();
      chk("midrst ready2", ready, 1'b0);
      chk("midrst busy", busy, 1'b0);
      chk("midrst count", frame_count, 8'd0);
      rst = 1'b0; valid = 1'b0;
      step();
      chk("postrst ready", ready, 1'b1);
      chk("postrst busy", busy, 1'b0);
      chk("postrst count", frame_count, 8'd0);
      chk("postrst no done", done_cnt - d0, 0);
      chk("postrst no err", err_cnt - e0, 0);

      d0 = done_cnt;
      stream(80, N, 0, 1'b0, 1'b0);
      step();
      chk("noarm done", done_cnt - d0, 0);
      chk("noarm busy", busy, 1'b0);
      memcheck("postrst");

      arm = 1'b1; step(); arm = 1'b0;
      stream(81, N, 0, 1'b0, 1'b1);
      step();
      chk("rearm done", done_at_eop, 1'b1);
      chk("rearm count", frame_count, 8'd1);
      chk("rearm busy", busy, 1'b0);
      memcheck("rearm");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
